// File: rtl/vdp_bus_pkg.sv
// Shared types for the host-CPU to VDP bridge: issue FSM states, write-FIFO entry
// layout and the host-bus bit-order swap.
package vdp_bus_pkg;

   // Upper bounds on the bridge widths; entries are sized to these and sliced down.
   localparam int unsigned ADR_W_MAX  = 8;
   localparam int unsigned DATA_W_MAX = 32;

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd
   } issue_state_e;

   typedef struct packed {
      logic [ADR_W_MAX-1:0]  adr;
      logic [DATA_W_MAX-1:0] data;
   } fifo_entry_t;

   // Reverses the low w bits of d; bits at and above w come back as zero.
   function automatic logic [DATA_W_MAX-1:0] bit_rev(input logic [DATA_W_MAX-1:0] d,
                                                     input int unsigned w);
      logic [DATA_W_MAX-1:0] r;
      for (int i = 0; i < DATA_W_MAX; i++) begin
         r[i] = d[DATA_W_MAX-1-i];
      end
      return r >> (DATA_W_MAX - w);
   endfunction

endpackage

// File: rtl/vdp_strobe_sync.sv
// Synchroniser with all-stages-agree hysteresis for one active-low host strobe.
// Emits the filtered level and a one-cycle pulse on its falling edge.
module vdp_strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic strobe_n_i,
   output logic level_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q  <= '1;
         level_o <= 1'b1;
         fall_o  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n_i};
         fall_o <= 1'b0;
         if (sync_q == '0) begin
            level_o <= 1'b0;
            fall_o  <= level_o;
         end else if (&sync_q) begin
            level_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vdp_cpu_bridge.sv
// Host strobe bridge in front of the VDP: filters the strobes, queues writes in a
// small FIFO and issues writes then reads to the VDP with a req/ack handshake.
module vdp_cpu_bridge
   import vdp_bus_pkg::*;
#(
   parameter int unsigned ADR_W       = 2,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BIT_REVERSE = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          csr_n,
   input  logic                          csw_n,
   input  logic [ADR_W-1:0]              mode,
   input  logic [DATA_W-1:0]             cd_in,
   output logic [DATA_W-1:0]             cd_out,
   output logic                          cd_oe,
   output logic                          vdp_req,
   output logic                          vdp_wrt,
   output logic [ADR_W-1:0]              vdp_adr,
   output logic [DATA_W-1:0]             vdp_dbo,
   input  logic                          vdp_ack,
   input  logic [DATA_W-1:0]             vdp_dbi,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PtrInc = (PTR_W+1)'(1);

   logic csr_level, csr_fall, csw_level, csw_fall;
   logic wr_event, rd_event, push, pop, fifo_empty, fifo_full;
   logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
   logic rd_pend_q;
   logic [ADR_W-1:0] rd_adr_q;
   issue_state_e state_q;
   fifo_entry_t fifo_mem [FIFO_DEPTH];
   fifo_entry_t wr_entry, head, issue_entry;
   logic [DATA_W_MAX-1:0] rd_rev;
   logic [DATA_W-1:0] rd_data;
   logic unused_bits;

   vdp_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csr_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .strobe_n_i (csr_n),
      .level_o    (csr_level),
      .fall_o     (csr_fall)
   );

   vdp_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csw_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .strobe_n_i (csw_n),
      .level_o    (csw_level),
      .fall_o     (csw_fall)
   );

   assign wr_event = csw_fall & csr_level;
   assign rd_event = csr_fall & csw_level;
   assign cd_oe    = ~csr_level;

   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (fifo_level == (PTR_W+1)'(FIFO_DEPTH));
   assign pop        = (state_q == StWr) & vdp_ack;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push       = wr_event & (~fifo_full | pop);
   assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_entry.adr  = ADR_W_MAX'(mode);
      wr_entry.data = (BIT_REVERSE != 0) ? bit_rev(DATA_W_MAX'(cd_in), DATA_W)
                                         : DATA_W_MAX'(cd_in);
      // An empty FIFO issues the entry being pushed this cycle directly.
      issue_entry   = fifo_empty ? wr_entry : head;
      rd_rev        = bit_rev(DATA_W_MAX'(vdp_dbi), DATA_W);
      rd_data       = (BIT_REVERSE != 0) ? rd_rev[DATA_W-1:0] : vdp_dbi;
   end

   assign unused_bits = ^{issue_entry, rd_rev};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         vdp_req   <= 1'b0;
         vdp_wrt   <= 1'b0;
         vdp_adr   <= '0;
         vdp_dbo   <= '0;
         cd_out    <= '0;
         rd_pend_q <= 1'b0;
         rd_adr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrInc;
         end
         if (wr_event && !push) begin
            overflow <= 1'b1;
         end
         if (rd_event && !rd_pend_q) begin
            rd_pend_q <= 1'b1;
            rd_adr_q  <= mode;
         end
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty || push) begin
                  state_q <= StWr;
                  vdp_req <= 1'b1;
                  vdp_wrt <= 1'b1;
                  vdp_adr <= issue_entry.adr[ADR_W-1:0];
                  vdp_dbo <= issue_entry.data[DATA_W-1:0];
               end else if (rd_pend_q || rd_event) begin
                  state_q <= StRd;
                  vdp_req <= 1'b1;
                  vdp_wrt <= 1'b0;
                  vdp_adr <= rd_pend_q ? rd_adr_q : mode;
               end
            end
            StWr: begin
               if (vdp_ack) begin
                  rd_ptr_q <= rd_ptr_q + PtrInc;
                  state_q  <= StIdle;
                  vdp_req  <= 1'b0;
               end
            end
            StRd: begin
               if (vdp_ack) begin
                  cd_out    <= rd_data;
                  rd_pend_q <= 1'b0;
                  state_q   <= StIdle;
                  vdp_req   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Directed bench for vdp_cpu_bridge: table of write/read vectors plus hand-written
// sequences for timing, FIFO overflow, ordering, glitch, strobe clash and reset.
module tb_vdp_cpu_bridge;

   localparam int unsigned ADR_W       = 2;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned SYNC_STAGES = 3;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              csr_n = 1'b1;
   logic              csw_n = 1'b1;
   logic [ADR_W-1:0]  mode = '0;
   logic [DATA_W-1:0] cd_in = '0;
   logic [DATA_W-1:0] cd_out;
   logic              cd_oe;
   logic              vdp_req;
   logic              vdp_wrt;
   logic [ADR_W-1:0]  vdp_adr;
   logic [DATA_W-1:0] vdp_dbo;
   logic              vdp_ack = 1'b0;
   logic [DATA_W-1:0] vdp_dbi = '0;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;

   int n_cmp = 0;
   int n_err = 0;

   vdp_cpu_bridge #(
      .ADR_W       (ADR_W),
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .BIT_REVERSE (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .csr_n      (csr_n),
      .csw_n      (csw_n),
      .mode       (mode),
      .cd_in      (cd_in),
      .cd_out     (cd_out),
      .cd_oe      (cd_oe),
      .vdp_req    (vdp_req),
      .vdp_wrt    (vdp_wrt),
      .vdp_adr    (vdp_adr),
      .vdp_dbo    (vdp_dbo),
      .vdp_ack    (vdp_ack),
      .vdp_dbi    (vdp_dbi),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              is_rd;
      logic [ADR_W-1:0]  mode;
      logic [DATA_W-1:0] data;  // cd_in for writes, vdp_dbi for reads
      logic [DATA_W-1:0] exp;   // vdp_dbo for writes, cd_out for reads
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic host_write(input logic [ADR_W-1:0] m, input logic [DATA_W-1:0] d);
      mode  = m;
      cd_in = d;
      csw_n = 1'b0;
      ticks(SYNC_STAGES + 3);
      csw_n = 1'b1;
      ticks(SYNC_STAGES + 2);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (vdp_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({name, " req"}, 32'(vdp_req), 32'd1);
   endtask

   task automatic ack_write(input string name, input logic [ADR_W-1:0] adr,
                            input logic [DATA_W-1:0] dbo);
      wait_req(name);
      check({name, " wrt"}, 32'(vdp_wrt), 32'd1);
      check({name, " adr"}, 32'(vdp_adr), 32'(adr));
      check({name, " dbo"}, 32'(vdp_dbo), 32'(dbo));
      vdp_ack = 1'b1;
      tick();
      vdp_ack = 1'b0;
      check({name, " req drop"}, 32'(vdp_req), 32'd0);
   endtask

   task automatic ack_read(input string name, input logic [ADR_W-1:0] adr,
                           input logic [DATA_W-1:0] dbi, input logic [DATA_W-1:0] exp_cd);
      wait_req(name);
      check({name, " wrt"}, 32'(vdp_wrt), 32'd0);
      check({name, " adr"}, 32'(vdp_adr), 32'(adr));
      vdp_dbi = dbi;
      vdp_ack = 1'b1;
      tick();
      vdp_ack = 1'b0;
      vdp_dbi = '0;
      check({name, " cd_out"}, 32'(cd_out), 32'(exp_cd));
      check({name, " req drop"}, 32'(vdp_req), 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b0, 2'd2, 8'h0F, 8'hF0};
      vecs[1] = '{1'b0, 2'd3, 8'h12, 8'h48};
      vecs[2] = '{1'b1, 2'd1, 8'h01, 8'h80};
      vecs[3] = '{1'b0, 2'd0, 8'hC0, 8'h03};
      vecs[4] = '{1'b1, 2'd3, 8'h06, 8'h60};
      vecs[5] = '{1'b1, 2'd0, 8'hFF, 8'hFF};

      // Reset state
      ticks(3);
      check("rst vdp_req", 32'(vdp_req), 0);
      check("rst vdp_wrt", 32'(vdp_wrt), 0);
      check("rst vdp_adr", 32'(vdp_adr), 0);
      check("rst vdp_dbo", 32'(vdp_dbo), 0);
      check("rst cd_out", 32'(cd_out), 0);
      check("rst cd_oe", 32'(cd_oe), 0);
      check("rst fifo_level", 32'(fifo_level), 0);
      check("rst overflow", 32'(overflow), 0);
      reset = 1'b0;
      ticks(2);

      // Single write latency: request SYNC_STAGES+2 clocks after csw_n falls
      mode  = 2'd1;
      cd_in = 8'h80;
      csw_n = 1'b0;
      ticks(SYNC_STAGES + 1);
      check("lat req early", 32'(vdp_req), 0);
      tick();
      check("lat req on time", 32'(vdp_req), 1);
      ticks(1);
      csw_n = 1'b1;
      ticks(SYNC_STAGES + 2);
      ack_write("single", 2'd1, 8'h01);
      ticks(2);
      check("single level", 32'(fifo_level), 0);

      // Table of write/read vectors
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_rd) begin
            mode  = vecs[i].mode;
            csr_n = 1'b0;
            ack_read($sformatf("vec%0d rd", i), vecs[i].mode, vecs[i].data, vecs[i].exp);
            check($sformatf("vec%0d cd_oe on", i), 32'(cd_oe), 1);
            csr_n = 1'b1;
            ticks(SYNC_STAGES + 2);
            check($sformatf("vec%0d cd_oe off", i), 32'(cd_oe), 0);
            check($sformatf("vec%0d cd_out hold", i), 32'(cd_out), 32'(vecs[i].exp));
         end else begin
            host_write(vecs[i].mode, vecs[i].data);
            ack_write($sformatf("vec%0d wr", i), vecs[i].mode, vecs[i].exp);
         end
         ticks(2);
      end

      // Burst of 6 writes with ack withheld
      host_write(2'd0, 8'h01);
      host_write(2'd1, 8'h02);
      host_write(2'd2, 8'h04);
      host_write(2'd3, 8'h08);
      host_write(2'd0, 8'h10);
      host_write(2'd1, 8'h20);
      check("burst level", 32'(fifo_level), 4);
      check("burst overflow", 32'(overflow), 1);
      ack_write("burst0", 2'd0, 8'h80);
      tick();
      check("burst reassert0", 32'(vdp_req), 1);
      ack_write("burst1", 2'd1, 8'h40);
      tick();
      check("burst reassert1", 32'(vdp_req), 1);
      ack_write("burst2", 2'd2, 8'h20);
      tick();
      check("burst reassert2", 32'(vdp_req), 1);
      ack_write("burst3", 2'd3, 8'h10);
      ticks(3);
      check("burst drained req", 32'(vdp_req), 0);
      check("burst drained level", 32'(fifo_level), 0);

      // Read queued behind two writes
      host_write(2'd1, 8'h80);
      host_write(2'd2, 8'h0F);
      mode  = 2'd3;
      csr_n = 1'b0;
      ticks(SYNC_STAGES + 3);
      check("order cd_oe", 32'(cd_oe), 1);
      check("order first is wr", 32'(vdp_wrt), 1);
      ack_write("order wr0", 2'd1, 8'h01);
      ack_write("order wr1", 2'd2, 8'hF0);
      ack_read("order rd", 2'd3, 8'h5A, 8'h5A);
      csr_n = 1'b1;
      ticks(SYNC_STAGES + 2);
      check("order cd_oe off", 32'(cd_oe), 0);

      // One-clock glitch on csw_n
      csw_n = 1'b0;
      tick();
      csw_n = 1'b1;
      ticks(8);
      check("glitch level", 32'(fifo_level), 0);
      check("glitch req", 32'(vdp_req), 0);

      // Both strobes low together
      csw_n = 1'b0;
      csr_n = 1'b0;
      ticks(8);
      check("clash level", 32'(fifo_level), 0);
      check("clash req", 32'(vdp_req), 0);
      check("clash cd_oe", 32'(cd_oe), 1);
      csw_n = 1'b1;
      csr_n = 1'b1;
      ticks(8);
      check("clash after req", 32'(vdp_req), 0);

      // Reset mid-transaction
      host_write(2'd1, 8'h01);
      host_write(2'd2, 8'h02);
      host_write(2'd3, 8'h03);
      check("mid level", 32'(fifo_level), 3);
      check("mid req", 32'(vdp_req), 1);
      reset = 1'b1;
      #1;
      check("mid rst req", 32'(vdp_req), 0);
      check("mid rst level", 32'(fifo_level), 0);
      check("mid rst overflow", 32'(overflow), 0);
      tick();
      reset = 1'b0;
      ticks(2);
      host_write(2'd2, 8'h80);
      ack_write("post rst", 2'd2, 8'h01);
      ticks(2);
      check("post rst level", 32'(fifo_level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
